// File: rtl/rv32_decode_stage.sv
// RV32I (+ optional RV32M) decode stage with a two-entry skid buffer for the barrel pito core.
// Define RV32_DEC_TRAP_CNT_EN to add per-hart 16-bit saturating trap counters on port trap_cnt.
module rv32_decode_stage #(
  parameter int NUM_HARTS = 8,
  parameter int M_EXT     = 0,
  parameter int PC_W      = 32,
  localparam int HART_W   = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [HART_W-1:0] in_hart,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_opcode,
  output logic [2:0]        out_type,
  output logic [3:0]        out_alu_op,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [31:0]       out_imm,
  output logic [4:0]        out_shamt,
  output logic [11:0]       out_csr,
  output logic [4:0]        out_zimm,
  output logic [3:0]        out_fence_pred,
  output logic [3:0]        out_fence_succ,
  output logic              out_muldiv,
  output logic              out_trap,
  output logic [PC_W-1:0]   out_pc,
  output logic [HART_W-1:0] out_hart
`ifdef RV32_DEC_TRAP_CNT_EN
  ,
  output logic [NUM_HARTS*16-1:0] trap_cnt
`endif
);

  // Zero encodings are the "nothing decoded" values so a cleared register reads as such.
  typedef enum logic [5:0] {
    RV32_UNKNOWN, RV32_LUI, RV32_AUIPC, RV32_JAL, RV32_JALR,
    RV32_BEQ, RV32_BNE, RV32_BLT, RV32_BGE, RV32_BLTU, RV32_BGEU,
    RV32_LB, RV32_LH, RV32_LW, RV32_LBU, RV32_LHU,
    RV32_SB, RV32_SH, RV32_SW,
    RV32_ADDI, RV32_SLTI, RV32_SLTIU, RV32_XORI, RV32_ORI, RV32_ANDI,
    RV32_SLLI, RV32_SRLI, RV32_SRAI,
    RV32_ADD, RV32_SUB, RV32_SLL, RV32_SLT, RV32_SLTU, RV32_XOR,
    RV32_SRL, RV32_SRA, RV32_OR, RV32_AND,
    RV32_FENCE, RV32_FENCE_I, RV32_ECALL, RV32_EBREAK,
    RV32_CSRRW, RV32_CSRRS, RV32_CSRRC, RV32_CSRRWI, RV32_CSRRSI, RV32_CSRRCI,
    RV32_NOP,
    RV32_MUL, RV32_MULH, RV32_MULHSU, RV32_MULHU,
    RV32_DIV, RV32_DIVU, RV32_REM, RV32_REMU
  } rv32_opcode_enum_t;

  typedef enum logic [2:0] {
    RV32_TYPE_UNKNOWN, RV32_TYPE_R, RV32_TYPE_I, RV32_TYPE_S,
    RV32_TYPE_B, RV32_TYPE_U, RV32_TYPE_J, RV32_TYPE_NOP
  } rv32_type_enum_t;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } rv32_alu_op_t;

  typedef struct packed {
    rv32_opcode_enum_t opcode;
    rv32_type_enum_t   typ;
    rv32_alu_op_t      alu_op;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic [4:0]        shamt;
    logic [11:0]       csr;
    logic [4:0]        zimm;
    logic [3:0]        pred;
    logic [3:0]        succ;
    logic              muldiv;
    logic              trap;
    logic [PC_W-1:0]   pc;
    logic [HART_W-1:0] hart;
  } bundle_t;

  logic [6:0]        w_major;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  rv32_opcode_enum_t w_opc;
  rv32_type_enum_t   w_typ;
  rv32_alu_op_t      w_alu;
  logic              w_muldiv;
  logic [31:0]       w_imm;
  bundle_t           w_dec;

  assign w_major = in_instr[6:0];
  assign w_f3    = in_instr[14:12];
  assign w_f7    = in_instr[31:25];

  // Format follows the major opcode; a bad minor field only makes the opcode unknown.
  always_comb begin
    w_opc    = RV32_UNKNOWN;
    w_typ    = RV32_TYPE_UNKNOWN;
    w_alu    = ALU_NOP;
    w_muldiv = 1'b0;
    case (w_major)
      7'b0110111: begin w_typ = RV32_TYPE_U; w_opc = RV32_LUI;   w_alu = ALU_ADD; end
      7'b0010111: begin w_typ = RV32_TYPE_U; w_opc = RV32_AUIPC; w_alu = ALU_ADD; end
      7'b1101111: begin w_typ = RV32_TYPE_J; w_opc = RV32_JAL;   w_alu = ALU_ADD; end
      7'b1100111: begin
        w_typ = RV32_TYPE_I;
        if (w_f3 == 3'b000) begin w_opc = RV32_JALR; w_alu = ALU_ADD; end
      end
      7'b1100011: begin
        w_typ = RV32_TYPE_B;
        case (w_f3)
          3'b000:  begin w_opc = RV32_BEQ;  w_alu = ALU_SUB;  end
          3'b001:  begin w_opc = RV32_BNE;  w_alu = ALU_SUB;  end
          3'b100:  begin w_opc = RV32_BLT;  w_alu = ALU_SLT;  end
          3'b101:  begin w_opc = RV32_BGE;  w_alu = ALU_SLT;  end
          3'b110:  begin w_opc = RV32_BLTU; w_alu = ALU_SLTU; end
          3'b111:  begin w_opc = RV32_BGEU; w_alu = ALU_SLTU; end
          default: ;
        endcase
      end
      7'b0000011: begin
        w_typ = RV32_TYPE_I;
        w_alu = ALU_ADD;
        case (w_f3)
          3'b000:  w_opc = RV32_LB;
          3'b001:  w_opc = RV32_LH;
          3'b010:  w_opc = RV32_LW;
          3'b100:  w_opc = RV32_LBU;
          3'b101:  w_opc = RV32_LHU;
          default: w_alu = ALU_NOP;
        endcase
      end
      7'b0100011: begin
        w_typ = RV32_TYPE_S;
        w_alu = ALU_ADD;
        case (w_f3)
          3'b000:  w_opc = RV32_SB;
          3'b001:  w_opc = RV32_SH;
          3'b010:  w_opc = RV32_SW;
          default: w_alu = ALU_NOP;
        endcase
      end
      7'b0010011: begin
        w_typ = RV32_TYPE_I;
        if (in_instr[31:7] == 25'd0) begin
          w_typ = RV32_TYPE_NOP;
          w_opc = RV32_NOP;
        end else begin
          case (w_f3)
            3'b000: begin w_opc = RV32_ADDI;  w_alu = ALU_ADD;  end
            3'b010: begin w_opc = RV32_SLTI;  w_alu = ALU_SLT;  end
            3'b011: begin w_opc = RV32_SLTIU; w_alu = ALU_SLTU; end
            3'b100: begin w_opc = RV32_XORI;  w_alu = ALU_XOR;  end
            3'b110: begin w_opc = RV32_ORI;   w_alu = ALU_OR;   end
            3'b111: begin w_opc = RV32_ANDI;  w_alu = ALU_AND;  end
            3'b001: if (w_f7 == 7'b0000000) begin w_opc = RV32_SLLI; w_alu = ALU_SLL; end
            default: begin
              if (w_f7 == 7'b0000000)      begin w_opc = RV32_SRLI; w_alu = ALU_SRL; end
              else if (w_f7 == 7'b0100000) begin w_opc = RV32_SRAI; w_alu = ALU_SRA; end
            end
          endcase
        end
      end
      7'b0110011: begin
        w_typ = RV32_TYPE_R;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  begin w_opc = RV32_ADD;  w_alu = ALU_ADD;  end
            3'b001:  begin w_opc = RV32_SLL;  w_alu = ALU_SLL;  end
            3'b010:  begin w_opc = RV32_SLT;  w_alu = ALU_SLT;  end
            3'b011:  begin w_opc = RV32_SLTU; w_alu = ALU_SLTU; end
            3'b100:  begin w_opc = RV32_XOR;  w_alu = ALU_XOR;  end
            3'b101:  begin w_opc = RV32_SRL;  w_alu = ALU_SRL;  end
            3'b110:  begin w_opc = RV32_OR;   w_alu = ALU_OR;   end
            default: begin w_opc = RV32_AND;  w_alu = ALU_AND;  end
          endcase
        end else if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'b000)      begin w_opc = RV32_SUB; w_alu = ALU_SUB; end
          else if (w_f3 == 3'b101) begin w_opc = RV32_SRA; w_alu = ALU_SRA; end
        end else if (w_f7 == 7'b0000001 && M_EXT != 0) begin
          w_muldiv = 1'b1;
          case (w_f3)
            3'b000:  w_opc = RV32_MUL;
            3'b001:  w_opc = RV32_MULH;
            3'b010:  w_opc = RV32_MULHSU;
            3'b011:  w_opc = RV32_MULHU;
            3'b100:  w_opc = RV32_DIV;
            3'b101:  w_opc = RV32_DIVU;
            3'b110:  w_opc = RV32_REM;
            default: w_opc = RV32_REMU;
          endcase
        end
      end
      7'b0001111: begin
        w_typ = RV32_TYPE_I;
        if (w_f3 == 3'b000 && in_instr[31:28] == 4'd0 && in_instr[19:15] == 5'd0 &&
            in_instr[11:7] == 5'd0)
          w_opc = RV32_FENCE;
        else if (w_f3 == 3'b001 && in_instr[31:15] == 17'd0 && in_instr[11:7] == 5'd0)
          w_opc = RV32_FENCE_I;
      end
      7'b1110011: begin
        w_typ = RV32_TYPE_I;
        case (w_f3)
          3'b000: begin
            if (in_instr == 32'h0000_0073)      w_opc = RV32_ECALL;
            else if (in_instr == 32'h0010_0073) w_opc = RV32_EBREAK;
          end
          3'b001:  w_opc = RV32_CSRRW;
          3'b010:  w_opc = RV32_CSRRS;
          3'b011:  w_opc = RV32_CSRRC;
          3'b101:  w_opc = RV32_CSRRWI;
          3'b110:  w_opc = RV32_CSRRSI;
          3'b111:  w_opc = RV32_CSRRCI;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    w_imm = 32'd0;
    case (w_typ)
      RV32_TYPE_I: w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
      RV32_TYPE_S: w_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      RV32_TYPE_B: w_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
      RV32_TYPE_U: w_imm = {in_instr[31:12], 12'd0};
      RV32_TYPE_J: w_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
      default:     w_imm = 32'd0;
    endcase
  end

  always_comb begin
    w_dec        = '0;
    w_dec.opcode = w_opc;
    w_dec.typ    = w_typ;
    w_dec.alu_op = w_alu;
    w_dec.rs1    = in_instr[19:15];
    w_dec.rs2    = in_instr[24:20];
    w_dec.rd     = in_instr[11:7];
    w_dec.imm    = w_imm;
    w_dec.shamt  = in_instr[24:20];
    w_dec.csr    = in_instr[31:20];
    if (w_opc == RV32_CSRRWI || w_opc == RV32_CSRRSI || w_opc == RV32_CSRRCI)
      w_dec.zimm = in_instr[19:15];
    if (w_opc == RV32_FENCE) begin
      w_dec.pred = in_instr[27:24];
      w_dec.succ = in_instr[23:20];
    end
    w_dec.muldiv = w_muldiv;
    w_dec.trap   = (w_typ == RV32_TYPE_UNKNOWN) || (w_opc == RV32_UNKNOWN);
    w_dec.pc     = in_pc;
    w_dec.hart   = in_hart;
  end

  bundle_t r_m;
  bundle_t r_s;
  logic    r_m_valid;
  logic    r_s_valid;
  logic    r_in_ready;
  logic    w_accept;
  logic    w_m_free;

  assign w_accept = in_valid && r_in_ready && !flush;
  assign w_m_free = !r_m_valid || out_ready;

  // in_ready is low whenever S holds data, so an S->M move never coincides with an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m        <= '0;
      r_s        <= '0;
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b0;
    end else if (flush) begin
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (w_m_free) begin
      r_in_ready <= 1'b1;
      if (r_s_valid) begin
        r_m       <= r_s;
        r_m_valid <= 1'b1;
        r_s_valid <= 1'b0;
      end else begin
        r_m_valid <= w_accept;
        if (w_accept) r_m <= w_dec;
      end
    end else if (w_accept) begin
      r_s        <= w_dec;
      r_s_valid  <= 1'b1;
      r_in_ready <= 1'b0;
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_m_valid;
  assign out_opcode     = r_m.opcode;
  assign out_type       = r_m.typ;
  assign out_alu_op     = r_m.alu_op;
  assign out_rs1        = r_m.rs1;
  assign out_rs2        = r_m.rs2;
  assign out_rd         = r_m.rd;
  assign out_imm        = r_m.imm;
  assign out_shamt      = r_m.shamt;
  assign out_csr        = r_m.csr;
  assign out_zimm       = r_m.zimm;
  assign out_fence_pred = r_m.pred;
  assign out_fence_succ = r_m.succ;
  assign out_muldiv     = r_m.muldiv;
  assign out_trap       = r_m.trap;
  assign out_pc         = r_m.pc;
  assign out_hart       = r_m.hart;

`ifdef RV32_DEC_TRAP_CNT_EN
  logic [15:0] r_trap_cnt [NUM_HARTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int h = 0; h < NUM_HARTS; h++) r_trap_cnt[h] <= 16'd0;
    end else if (r_m_valid && out_ready && r_m.trap &&
                 r_trap_cnt[r_m.hart] != 16'hFFFF) begin
      r_trap_cnt[r_m.hart] <= r_trap_cnt[r_m.hart] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_trap_cnt
    assign trap_cnt[g*16 +: 16] = r_trap_cnt[g];
  end
`endif

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed bench for rv32_decode_stage: decode vector table plus skid/flush/reset sequences.
module tb_rv32_decode_stage;
  localparam int NH = 8;

  localparam logic [5:0] OP_UNK = 6'd0,  OP_LUI = 6'd1,  OP_JAL = 6'd3,  OP_BEQ = 6'd5;
  localparam logic [5:0] OP_LW = 6'd13, OP_SW = 6'd18, OP_ADDI = 6'd19, OP_SRAI = 6'd27;
  localparam logic [5:0] OP_SUB = 6'd29, OP_FENCE = 6'd38, OP_ECALL = 6'd40, OP_EBREAK = 6'd41;
  localparam logic [5:0] OP_CSRRWI = 6'd45, OP_NOP = 6'd48, OP_MUL = 6'd49;
  localparam logic [2:0] T_UNK = 3'd0, T_R = 3'd1, T_I = 3'd2, T_S = 3'd3;
  localparam logic [2:0] T_B = 3'd4, T_U = 3'd5, T_J = 3'd6, T_NOP = 3'd7;
  localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_SRA = 4'd8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [2:0]  in_hart;

  logic in_ready, out_valid, out_muldiv, out_trap;
  logic [5:0] out_opcode;
  logic [2:0] out_type, out_hart;
  logic [3:0] out_alu_op, out_fence_pred, out_fence_succ;
  logic [4:0] out_rs1, out_rs2, out_rd, out_shamt, out_zimm;
  logic [31:0] out_imm, out_pc;
  logic [11:0] out_csr;

  logic m_in_ready, m_out_valid, m_out_muldiv, m_out_trap;
  logic [5:0] m_out_opcode;
  logic [2:0] m_out_type, m_out_hart;
  logic [3:0] m_out_alu_op, m_out_fence_pred, m_out_fence_succ;
  logic [4:0] m_out_rs1, m_out_rs2, m_out_rd, m_out_shamt, m_out_zimm;
  logic [31:0] m_out_imm, m_out_pc;
  logic [11:0] m_out_csr;

`ifdef RV32_DEC_TRAP_CNT_EN
  logic [NH*16-1:0] trap_cnt, m_trap_cnt;
`endif

  rv32_decode_stage #(.NUM_HARTS(NH), .M_EXT(0), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_hart(in_hart), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_type(out_type), .out_alu_op(out_alu_op),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_shamt(out_shamt), .out_csr(out_csr), .out_zimm(out_zimm),
    .out_fence_pred(out_fence_pred), .out_fence_succ(out_fence_succ),
    .out_muldiv(out_muldiv), .out_trap(out_trap), .out_pc(out_pc), .out_hart(out_hart)
`ifdef RV32_DEC_TRAP_CNT_EN
    , .trap_cnt(trap_cnt)
`endif
  );

  rv32_decode_stage #(.NUM_HARTS(NH), .M_EXT(1), .PC_W(32)) dut_m (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(m_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_hart(in_hart), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_opcode(m_out_opcode), .out_type(m_out_type), .out_alu_op(m_out_alu_op),
    .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_rd(m_out_rd), .out_imm(m_out_imm),
    .out_shamt(m_out_shamt), .out_csr(m_out_csr), .out_zimm(m_out_zimm),
    .out_fence_pred(m_out_fence_pred), .out_fence_succ(m_out_fence_succ),
    .out_muldiv(m_out_muldiv), .out_trap(m_out_trap), .out_pc(m_out_pc), .out_hart(m_out_hart)
`ifdef RV32_DEC_TRAP_CNT_EN
    , .trap_cnt(m_trap_cnt)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  hart;
    logic [5:0]  op;
    logic [2:0]  typ;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        trap;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  zimm;
    logic [3:0]  pred;
    logic [3:0]  succ;
    logic [5:0]  mop;
    logic        mtrap;
    logic        mmul;
  } vec_t;

  vec_t vt [16];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_cnt [NH];
    vec_t v;
    for (int h = 0; h < NH; h++) exp_cnt[h] = 16'd0;

    // instr, hart, op, type, alu, imm, trap, rd, rs1, zimm, pred, succ, op(M), trap(M), muldiv(M)
    vt[0]  = '{32'h00000013, 3'd3, OP_NOP,    T_NOP, A_NOP, 32'h00000000, 1'b0, 5'd0,  5'd0, 5'd0, 4'h0, 4'h0, OP_NOP,    1'b0, 1'b0};
    vt[1]  = '{32'h00A28293, 3'd1, OP_ADDI,   T_I,   A_ADD, 32'h0000000A, 1'b0, 5'd5,  5'd5, 5'd0, 4'h0, 4'h0, OP_ADDI,   1'b0, 1'b0};
    vt[2]  = '{32'h02B50533, 3'd2, OP_UNK,    T_R,   A_NOP, 32'h00000000, 1'b1, 5'd10, 5'd10,5'd0, 4'h0, 4'h0, OP_MUL,    1'b0, 1'b1};
    vt[3]  = '{32'h402081B3, 3'd4, OP_SUB,    T_R,   A_SUB, 32'h00000000, 1'b0, 5'd3,  5'd1, 5'd0, 4'h0, 4'h0, OP_SUB,    1'b0, 1'b0};
    vt[4]  = '{32'hFFC12303, 3'd5, OP_LW,     T_I,   A_ADD, 32'hFFFFFFFC, 1'b0, 5'd6,  5'd2, 5'd0, 4'h0, 4'h0, OP_LW,     1'b0, 1'b0};
    vt[5]  = '{32'h00512423, 3'd6, OP_SW,     T_S,   A_ADD, 32'h00000008, 1'b0, 5'd8,  5'd2, 5'd0, 4'h0, 4'h0, OP_SW,     1'b0, 1'b0};
    vt[6]  = '{32'hFE208CE3, 3'd7, OP_BEQ,    T_B,   A_SUB, 32'hFFFFFFF8, 1'b0, 5'd25, 5'd1, 5'd0, 4'h0, 4'h0, OP_BEQ,    1'b0, 1'b0};
    vt[7]  = '{32'h123452B7, 3'd0, OP_LUI,    T_U,   A_ADD, 32'h12345000, 1'b0, 5'd5,  5'd8, 5'd0, 4'h0, 4'h0, OP_LUI,    1'b0, 1'b0};
    vt[8]  = '{32'h010000EF, 3'd1, OP_JAL,    T_J,   A_ADD, 32'h00000010, 1'b0, 5'd1,  5'd0, 5'd0, 4'h0, 4'h0, OP_JAL,    1'b0, 1'b0};
    vt[9]  = '{32'h3002D073, 3'd2, OP_CSRRWI, T_I,   A_NOP, 32'h00000300, 1'b0, 5'd0,  5'd5, 5'd5, 4'h0, 4'h0, OP_CSRRWI, 1'b0, 1'b0};
    vt[10] = '{32'h0FF0000F, 3'd3, OP_FENCE,  T_I,   A_NOP, 32'h000000FF, 1'b0, 5'd0,  5'd0, 5'd0, 4'hF, 4'hF, OP_FENCE,  1'b0, 1'b0};
    vt[11] = '{32'h00000073, 3'd4, OP_ECALL,  T_I,   A_NOP, 32'h00000000, 1'b0, 5'd0,  5'd0, 5'd0, 4'h0, 4'h0, OP_ECALL,  1'b0, 1'b0};
    vt[12] = '{32'h0000007F, 3'd2, OP_UNK,    T_UNK, A_NOP, 32'h00000000, 1'b1, 5'd0,  5'd0, 5'd0, 4'h0, 4'h0, OP_UNK,    1'b1, 1'b0};
    vt[13] = '{32'h40101093, 3'd6, OP_UNK,    T_I,   A_NOP, 32'h00000401, 1'b1, 5'd1,  5'd0, 5'd0, 4'h0, 4'h0, OP_UNK,    1'b1, 1'b0};
    vt[14] = '{32'h4030D093, 3'd7, OP_SRAI,   T_I,   A_SRA, 32'h00000403, 1'b0, 5'd1,  5'd1, 5'd0, 4'h0, 4'h0, OP_SRAI,   1'b0, 1'b0};
    vt[15] = '{32'h00100073, 3'd0, OP_EBREAK, T_I,   A_NOP, 32'h00000001, 1'b0, 5'd0,  5'd0, 5'd0, 4'h0, 4'h0, OP_EBREAK, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0; in_hart = 3'd0;

    // Reset state
    tick; tick;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.opcode", out_opcode, OP_UNK);
    chk("rst.type", out_type, T_UNK);
    chk("rst.alu", out_alu_op, A_NOP);
    chk("rst.imm", out_imm, 0);
    chk("rst.trap", out_trap, 0);
    chk("rst.in_ready", in_ready, 0);
    rst = 1'b0;
    tick;
    chk("rst.in_ready_after", in_ready, 1);
    chk("rst.out_valid_after", out_valid, 0);

    // Decode table, streamed one per cycle with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = vt[i];
      in_valid = 1'b1;
      in_instr = v.instr;
      in_pc    = 32'h1000 + 32'(4 * i);
      in_hart  = v.hart;
      chk($sformatf("v%0d.in_ready", i), in_ready, 1);
      tick;
      chk($sformatf("v%0d.valid", i), out_valid, 1);
      chk($sformatf("v%0d.opcode", i), out_opcode, v.op);
      chk($sformatf("v%0d.type", i), out_type, v.typ);
      chk($sformatf("v%0d.alu", i), out_alu_op, v.alu);
      chk($sformatf("v%0d.imm", i), out_imm, v.imm);
      chk($sformatf("v%0d.trap", i), out_trap, v.trap);
      chk($sformatf("v%0d.rd", i), out_rd, v.rd);
      chk($sformatf("v%0d.rs1", i), out_rs1, v.rs1);
      chk($sformatf("v%0d.rs2", i), out_rs2, v.instr[24:20]);
      chk($sformatf("v%0d.shamt", i), out_shamt, v.instr[24:20]);
      chk($sformatf("v%0d.csr", i), out_csr, v.instr[31:20]);
      chk($sformatf("v%0d.zimm", i), out_zimm, v.zimm);
      chk($sformatf("v%0d.pred", i), out_fence_pred, v.pred);
      chk($sformatf("v%0d.succ", i), out_fence_succ, v.succ);
      chk($sformatf("v%0d.muldiv", i), out_muldiv, 0);
      chk($sformatf("v%0d.pc", i), out_pc, 32'h1000 + 32'(4 * i));
      chk($sformatf("v%0d.hart", i), out_hart, v.hart);
      chk($sformatf("v%0d.m_opcode", i), m_out_opcode, v.mop);
      chk($sformatf("v%0d.m_trap", i), m_out_trap, v.mtrap);
      chk($sformatf("v%0d.m_muldiv", i), m_out_muldiv, v.mmul);
      if (v.trap) exp_cnt[v.hart] = exp_cnt[v.hart] + 16'd1;
    end
    in_valid = 1'b0;
    tick;
    chk("stream.drained", out_valid, 0);
`ifdef RV32_DEC_TRAP_CNT_EN
    for (int h = 0; h < NH; h++)
      chk($sformatf("trap_cnt[%0d]", h), trap_cnt[h*16 +: 16], exp_cnt[h]);
`endif

    // Skid: A, B, C back-to-back with out_ready low for 3 cycles after A
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00A28293; in_pc = 32'h200; in_hart = 3'd1;
    tick;
    chk("skid.A_valid", out_valid, 1);
    chk("skid.A_op", out_opcode, OP_ADDI);
    chk("skid.ready1", in_ready, 1);
    in_instr = 32'h402081B3; in_pc = 32'h204; in_hart = 3'd2;
    tick;
    chk("skid.A_held", out_opcode, OP_ADDI);
    chk("skid.A_pc_held", out_pc, 32'h200);
    chk("skid.S_full_ready", in_ready, 0);
    in_instr = 32'h123452B7; in_pc = 32'h208; in_hart = 3'd3;
    tick;
    chk("skid.A_held2", out_opcode, OP_ADDI);
    chk("skid.C_stall_ready", in_ready, 0);
    out_ready = 1'b1;
    tick;
    chk("skid.B_valid", out_valid, 1);
    chk("skid.B_op", out_opcode, OP_SUB);
    chk("skid.B_hart", out_hart, 2);
    chk("skid.ready_back", in_ready, 1);
    tick;
    chk("skid.C_valid", out_valid, 1);
    chk("skid.C_op", out_opcode, OP_LUI);
    chk("skid.C_pc", out_pc, 32'h208);
    in_valid = 1'b0;
    tick;
    chk("skid.no_dup", out_valid, 0);

    // Flush with M and S both full
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00A28293; in_pc = 32'h300; in_hart = 3'd1;
    tick;
    in_instr = 32'h402081B3; in_pc = 32'h304;
    tick;
    chk("flush.pre_ready", in_ready, 0);
    flush = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h308;
    tick;
    flush = 1'b0;
    chk("flush.out_valid", out_valid, 0);
    chk("flush.in_ready", in_ready, 1);
    out_ready = 1'b1;
    in_instr = 32'h010000EF; in_pc = 32'h2000; in_hart = 3'd5;
    tick;
    chk("flush.next_valid", out_valid, 1);
    chk("flush.next_op", out_opcode, OP_JAL);
    chk("flush.next_hart", out_hart, 5);
    chk("flush.next_pc", out_pc, 32'h2000);
    in_valid = 1'b0;
    tick;
    chk("flush.next_drained", out_valid, 0);

    // Flush discards the input offered in the flush cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00A28293; in_pc = 32'h400; in_hart = 3'd0;
    tick;
    chk("flush2.ready_open", in_ready, 1);
    flush = 1'b1; in_instr = 32'h402081B3;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2.discard", out_valid, 0);
    tick;
    chk("flush2.stay_empty", out_valid, 0);

    // Reset in the middle of a stall
    in_valid = 1'b1; in_instr = 32'h02B50533; in_pc = 32'h500; in_hart = 3'd2;
    tick;
    in_instr = 32'h00A28293; in_pc = 32'h504;
    tick;
    chk("mrst.stalled", in_ready, 0);
    in_valid = 1'b0; rst = 1'b1;
    tick;
    chk("mrst.out_valid", out_valid, 0);
    chk("mrst.opcode", out_opcode, OP_UNK);
    chk("mrst.trap", out_trap, 0);
    chk("mrst.in_ready", in_ready, 0);
`ifdef RV32_DEC_TRAP_CNT_EN
    chk("mrst.trap_cnt_lo", trap_cnt[63:0], 0);
    chk("mrst.trap_cnt_hi", trap_cnt[127:64], 0);
`endif
    rst = 1'b0;
    tick;
    chk("mrst.in_ready_after", in_ready, 1);
    chk("mrst.out_valid_after", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
- Registered, handshaked decode stage for the multi-hart (barrel) pito core; sits between fetch and the register-file/execute stages.
- Decodes RV32I plus optional RV32M per instruction, tags each result with hart id and PC.
- Two-entry skid buffer gives full-throughput valid/ready flow with a registered in_ready.
- Adds synchronous flush, and trap on unknown opcode as well as unknown type.

Parameters:
- NUM_HARTS, 8, number of hardware threads; HART_W = $clog2(NUM_HARTS), minimum 1.
- M_EXT, 0, 1 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 makes them illegal.
- PC_W, 32, width of the PC sideband.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- flush  in  1  drop all buffered/in-flight instructions
- in_valid  in  1  fetch word valid
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word (rv32_instr_t)
- in_pc  in  PC_W  instruction PC
- in_hart  in  HART_W  issuing hart id
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_opcode  out  rv32_opcode_enum_t  decoded opcode
- out_type  out  rv32_type_enum_t  instruction format
- out_alu_op  out  rv32_alu_op_t  ALU operation
- out_rs1/out_rs2/out_rd  out  5 each  instr[19:15]/[24:20]/[11:7]
- out_imm  out  32  sign-extended immediate per out_type
- out_shamt  out  5  instr[24:20]
- out_csr  out  12  instr[31:20]
- out_zimm  out  5  instr[19:15], zero when not CSR*I
- out_fence_pred/out_fence_succ  out  4 each  instr[27:24]/[23:20] for FENCE, else 0
- out_muldiv  out  1  RV32M instruction
- out_trap  out  1  illegal instruction
- out_pc  out  PC_W  passthrough
- out_hart  out  HART_W  passthrough

Behaviour:
- Decode is combinational on in_instr, registered on acceptance; every field is deterministic (no latched hold-over; unset fields drive 0 / ALU_NOP).
- Opcode map per RV32I: LUI/AUIPC U, JAL J, JALR I (funct3 000 only), branches B, loads/OP-IMM/FENCE/SYSTEM I, stores S, OP R.
- OP-IMM with instr[31:7]==0 -> RV32_NOP, type RV32_TYPE_NOP, trap 0.
- SLLI needs funct7 0; SRLI/SRAI need funct7 0000000/0100000; FENCE needs {[31:28],[19:15],[11:7]}==0; FENCE.I needs {[31:15],[11:7]}==0; ECALL/EBREAK exact encodings.
- OP with funct7 0000001: M_EXT=1 -> RV32M opcode, out_muldiv=1, alu_op ALU_NOP; M_EXT=0 -> RV32_UNKNOWN.
- out_trap = (type==RV32_TYPE_UNKNOWN) || (opcode==RV32_UNKNOWN). Trapping instructions still flow downstream with pc/hart.
- Handshake: transfer when valid&&ready on each side. Data must not change while out_valid && !out_ready.
- Buffer: main reg M drives outputs; skid reg S. in_ready = !S_valid (registered).
- Accept with M empty or M draining -> into M; accept while M stalled -> into S. When M drains and S valid, S moves to M the same cycle.
- Latency 1 cycle in->out; sustained 1 instr/cycle with out_ready held high.
- Simultaneous accept, drain and S valid cannot occur (in_ready=0 when S valid).
- flush: next cycle M_valid=S_valid=0, in_ready=1. Input presented in the flush cycle is discarded. Flush overrides acceptance.
- Reset (also mid-operation): out_valid=0, in_ready=1 after reset, all out_* data = 0, out_opcode=RV32_UNKNOWN, out_type=RV32_TYPE_UNKNOWN, out_alu_op=ALU_NOP. in_ready is 0 during the reset cycle.

Optional Feature:
- RV32_DEC_TRAP_CNT_EN
- Defined: adds output trap_cnt [NUM_HARTS*16-1:0], one 16-bit saturating counter per hart.
  - Counter increments when a bundle with out_trap=1 transfers at the output, indexed by out_hart.
  - Holds at 0xFFFF.
  - Cleared by rst, not by flush.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- 0x00000013 hart 3, out_ready=1 -> next cycle out_valid=1, opcode RV32_NOP, type RV32_TYPE_NOP, trap 0, hart 3.
- 0x00A28293 (addi x5,x5,10) -> RV32_ADDI, ALU_ADD, rs1=5, rd=5, imm=0x0000000A, type I.
- 0x02B50533 (mul x10,x10,x11): M_EXT=1 -> RV32_MUL, muldiv 1, trap 0. M_EXT=0 -> RV32_UNKNOWN, trap 1; with RV32_DEC_TRAP_CNT_EN that hart's count becomes 1.
- Back-to-back stream A,B,C with out_ready low for 3 cycles after A -> B held in S, in_ready=0, C stalls. On release, outputs A,B,C in order, no loss or duplicate.
- Flush asserted while M and S both full -> next cycle out_valid=0, in_ready=1; a subsequent instruction appears 1 cycle after acceptance.
- rst asserted mid-stall -> next cycle out_valid=0, out_opcode=RV32_UNKNOWN, trap_cnt=0, in_ready=1 one cycle after rst deasserts.
